// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding,
// slice width and the two's-complement overflow helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of the top slice: operand signs agree but the
    // result sign differs.
    function automatic logic add_ovf(
        input logic sa,
        input logic sb,
        input logic ss
    );
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder used as the per-slice adder.
// Ports: a_i, b_i (slice operands), c_i (carry-in),
//        s_o (slice sum), c_o (slice carry-out).
module ripple_carry_adder_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);

    logic [NIBBLE_W:0] cy;

    always_comb begin
        cy    = '0;
        s_o   = '0;
        cy[0] = c_i;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s_o[i]    = a_i[i] ^ b_i[i] ^ cy[i];
            cy[i + 1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = cy[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: captures a, b, cin on an input handshake, adds
// one 4-bit slice per cycle, then holds sum/cout until out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready input
//        handshake with a, b, cin; out_valid/out_ready output
//        handshake with sum, cout; busy (not IDLE).
// Optional: define NIBBLE_SERIAL_ADDER_OVF_EN to add the ovf output
//        (two's-complement overflow, valid with cout).
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic                    ovf,
`endif
    output logic                    busy
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [KW-1:0]  k_q, k_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;

    logic [NIBBLE_W-1:0] sl_a;
    logic [NIBBLE_W-1:0] sl_b;
    logic [NIBBLE_W-1:0] sl_s;
    logic                sl_c;

    // Slice k of the captured operands; operands never shift.
    assign sl_a = a_q[k_q*NIBBLE_W +: NIBBLE_W];
    assign sl_b = b_q[k_q*NIBBLE_W +: NIBBLE_W];

    ripple_carry_adder_4bit u_rca (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (carry_q),
        .s_o (sl_s),
        .c_o (sl_c)
    );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*NIBBLE_W +: NIBBLE_W] = sl_s;
                carry_d = sl_c;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // Final slice: latch carry-out and finish.
                    cout_d  = sl_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = add_ovf(sl_a[NIBBLE_W-1],
                                      sl_b[NIBBLE_W-1],
                                      sl_s[NIBBLE_W-1]);
`endif
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES, legal range 2..8.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand transfer request.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  operand A, sampled on input handshake.
REQ-007 SHALL have port b  input  W  operand B, sampled on input handshake.
REQ-008 SHALL have port cin  input  1  carry-in, sampled on input handshake.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  W  result sum.
REQ-012 SHALL have port cout  output  1  final carry-out.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 An input handshake (in_valid && in_ready) SHALL capture a, b and cin into registers, clear the slice index to 0, and move the FSM to RUN.
REQ-017 In RUN, each cycle SHALL add slice k of A and B plus the carry register through one 4-bit adder, write sum bits [4k+3:4k], store the slice carry-out in the carry register, and increment k.
REQ-018 When k = NIBBLES-1 completes, the FSM SHALL enter DONE; out_valid SHALL assert exactly NIBBLES cycles after the handshake edge.
REQ-019 In DONE, out_valid SHALL be 1, and sum and cout SHALL hold stable until out_ready is 1.
REQ-020 The output handshake (out_valid && out_ready) SHALL move the FSM to IDLE, with in_ready asserting in the following cycle; the design SHALL provide no same-cycle bypass.
REQ-021 in_valid asserted outside IDLE SHALL be ignored, with no capture and no error.
REQ-022 Arithmetic SHALL be unsigned modulo 2^W, with cout = bit W of a+b+cin.
REQ-023 sum SHALL update only during RUN; partial values SHALL be visible during RUN, and the result is valid only when out_valid = 1.

Reset
REQ-024 On rst, the FSM SHALL go to IDLE, and sum, cout, out_valid, busy, the slice index and the carry register SHALL all be 0.
REQ-025 In IDLE, in_ready SHALL be 1 (combinational from state) while rst is asserted and after it is released.
REQ-026 rst asserted in RUN or DONE SHALL abort the operation immediately, with no result delivered afterwards.

Configuration
REQ-027 Macro NIBBLE_SERIAL_ADDER_OVF_EN defined SHALL add port ovf  output  1  two's-complement overflow, registered with cout in the final RUN cycle, held through DONE, and reset to 0.
REQ-028 Without NIBBLE_SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package nibble_serial_adder_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and localparam NIBBLE_W=4.
REQ-030 The block SHALL instantiate exactly one ripple_carry_adder_4bit as its per-slice adder, with no other sub-modules.
REQ-031 Slice selection SHALL be an indexed part-select of the operand registers on k; operands SHALL NOT be shifted.

Verification
REQ-032 Carry ripple: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after the handshake, sum=0x0000, cout=1.
REQ-033 Carry-in use: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-034 Backpressure: out_ready held 0 for 3 cycles in DONE -> sum and cout stable, in_ready=0, busy=1; out_ready=1 -> IDLE, in_ready=1 in the next cycle.
REQ-035 Abort: rst pulsed in the 2nd RUN cycle of a=0xAAAA, b=0x5555 -> all outputs 0, in_ready=1, and no out_valid afterwards.
REQ-036 Ignored input: in_valid=1 with new operands during RUN -> the first result a+b is unchanged and only one out_valid pulse-train occurs.
REQ-037 Overflow (macro defined): a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; with a=0xFFFF, b=0x0001 -> ovf=0.
